// File: rtl/cam_pkg.sv
// Shared definitions for the camera-to-UDP path: colour-mode encodings,
// pixel sizing and the line-packet scheduler state encoding.
package cam_pkg;

  localparam int CM_GRAY   = 32'sd1;
  localparam int CM_RGB565 = 32'sd2;
  localparam int CM_RAW    = 32'sd3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARM       = 3'd1,
    ST_WAIT_DATA = 3'd2,
    ST_REQ       = 3'd3,
    ST_SEND      = 3'd4,
    ST_FLUSH     = 3'd5
  } sched_state_t;

  // Only grayscale packs one byte per pixel; both RGB565 flavours use two.
  function automatic int bytes_per_pixel(input int mode);
    return (mode == CM_GRAY) ? 32'sd1 : 32'sd2;
  endfunction

endpackage

// File: rtl/sched_watchdog.sv
// Loadable down-counter that flags expiry once it has run down to zero
// without being reloaded.
module sched_watchdog #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt;

  // Reload while the watched wait is not in progress, otherwise run down and hold at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= {W{1'b0}};
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != {W{1'b0}}) begin
      cnt <= cnt - {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt <= cnt;
    end
  end

  assign expired = !load && (cnt == {W{1'b0}});

endmodule

// File: rtl/video_pkt_sched.sv
// Line-packet scheduler: issues one UDP packet request per buffered image line
// and aborts/resyncs the frame on FIFO overflow or premature VSYNC.
// Optional watchdog on long waits is enabled by defining VIDEO_SCHED_TIMEOUT_EN.
module video_pkt_sched
  import cam_pkg::*;
#(
  parameter int COLOR_MODE     = 1,
  parameter int IM_X           = 1280,
  parameter int IM_Y           = 720,
  parameter int FIFO_AW        = 12,
  parameter int TIMEOUT_CYCLES = 16777216
) (
  input  logic             gtx_clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             frame_start,
  input  logic [FIFO_AW:0] fifo_level,
  input  logic             fifo_overflow,
  output logic             out_ready,
  output logic             fifo_flush,
  output logic             pkt_req,
  input  logic             pkt_ack,
  input  logic             pkt_done,
  output logic [15:0]      pkt_len,
  output logic [15:0]      frame_num,
  output logic [15:0]      line_num,
  output logic             frame_err
);

  localparam int               LINE_BYTES = IM_X * bytes_per_pixel(COLOR_MODE);
  localparam logic [FIFO_AW:0] LINE_LVL   = (FIFO_AW+1)'(LINE_BYTES);
  localparam logic [15:0]      LAST_LINE  = 16'(IM_Y - 1);

  if (LINE_BYTES >= (32'sd1 << FIFO_AW)) begin : g_line_too_long
    $error("video_pkt_sched: one line does not fit in the pixel FIFO");
  end
  if ((COLOR_MODE != CM_GRAY) && (COLOR_MODE != CM_RGB565) && (COLOR_MODE != CM_RAW)) begin : g_bad_mode
    $error("video_pkt_sched: unsupported COLOR_MODE");
  end
  if (TIMEOUT_CYCLES < 32'sd2) begin : g_bad_timeout
    $error("video_pkt_sched: TIMEOUT_CYCLES must be at least 2");
  end

  sched_state_t state;
  logic         premature;
  logic         abort;
  logic         wd_expired;

  assign pkt_len = 16'(LINE_BYTES);

`ifdef VIDEO_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES);
  logic wd_load;

  assign wd_load = !((state == ST_WAIT_DATA) || ((state == ST_SEND) && !pkt_done));

  sched_watchdog #(
    .W(WD_W)
  ) u_watchdog (
    .clk      (gtx_clk),
    .rst      (rst),
    .load     (wd_load),
    .load_val (WD_W'(TIMEOUT_CYCLES - 1)),
    .expired  (wd_expired)
  );
`else
  assign wd_expired = 1'b0;
`endif

  // Frame-abort sources; overflow dominates, and a VSYNC seen during a packet
  // only takes effect once that packet's payload has been drained.
  always_comb begin
    case (state)
      ST_ARM:       abort = fifo_overflow;
      ST_WAIT_DATA: abort = fifo_overflow | frame_start | wd_expired;
      ST_REQ:       abort = fifo_overflow;
      ST_SEND:      abort = fifo_overflow | wd_expired | (pkt_done & (premature | frame_start));
      default:      abort = 1'b0;
    endcase
  end

  // Scheduler FSM with registered Moore outputs.
  always_ff @(posedge gtx_clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      out_ready  <= 1'b0;
      fifo_flush <= 1'b0;
      pkt_req    <= 1'b0;
      frame_num  <= 16'd0;
      line_num   <= 16'd0;
      frame_err  <= 1'b0;
      premature  <= 1'b0;
    end else if (abort) begin
      state      <= ST_FLUSH;
      out_ready  <= 1'b0;
      fifo_flush <= 1'b1;
      frame_err  <= 1'b1;
      pkt_req    <= 1'b0;
      premature  <= 1'b0;
    end else begin
      fifo_flush <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (enable) begin
            state     <= ST_ARM;
            out_ready <= 1'b1;
          end
        end
        ST_ARM: begin
          if (frame_start) begin
            state     <= ST_WAIT_DATA;
            line_num  <= 16'd0;
            premature <= 1'b0;
          end else if (!enable) begin
            state     <= ST_IDLE;
            out_ready <= 1'b0;
          end
        end
        ST_WAIT_DATA: begin
          if (fifo_level >= LINE_LVL) begin
            state   <= ST_REQ;
            pkt_req <= 1'b1;
          end
        end
        ST_REQ: begin
          if (frame_start) begin
            premature <= 1'b1;
          end
          if (pkt_ack) begin
            state   <= ST_SEND;
            pkt_req <= 1'b0;
          end
        end
        ST_SEND: begin
          if (pkt_done) begin
            if (line_num == LAST_LINE) begin
              frame_num <= frame_num + 16'd1;
              state     <= enable ? ST_ARM : ST_IDLE;
              out_ready <= enable;
            end else begin
              line_num <= line_num + 16'd1;
              state    <= ST_WAIT_DATA;
            end
          end else if (frame_start) begin
            premature <= 1'b1;
          end
        end
        ST_FLUSH: begin
          state     <= enable ? ST_ARM : ST_IDLE;
          out_ready <= enable;
        end
        default: begin
          state     <= ST_IDLE;
          out_ready <= 1'b0;
          pkt_req   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/video_pkt_sched.md
# video_pkt_sched

Line-packet scheduler for the camera-to-UDP path, running in the `gtx_clk` domain. It gates the capture datapath through `out_ready` and watches the pixel FIFO fill level. Once a full image line is buffered, it issues one UDP packet request to the transmitter, tagged with frame and line numbers. It also detects overflow and premature-VSYNC conditions, flushes the FIFO and resynchronises on the next frame.

## Interface
Parameters:
- `COLOR_MODE`, 1 — 1: grayscale, 1 byte/pixel; 2: RGB565 pass-through, 2 bytes/pixel; 3: RAW→RGB565, 2 bytes/pixel.
- `IM_X`, 1280 — pixels per line.
- `IM_Y`, 720 — lines per frame.
- `FIFO_AW`, 12 — pixel FIFO address width in bytes.
- `TIMEOUT_CYCLES`, 16777216 — watchdog limit; used only with the macro.

Ports:
- `gtx_clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  streaming enable (level).
- `frame_start`  in  1  one-cycle pulse: VSYNC falling edge, already synchronised to `gtx_clk`.
- `fifo_level`  in  FIFO_AW+1  bytes currently in the pixel FIFO.
- `fifo_overflow`  in  1  sticky-free pulse: FIFO write attempted while full.
- `out_ready`  out  1  capture enable to the capture block.
- `fifo_flush`  out  1  one-cycle FIFO clear.
- `pkt_req`  out  1  packet request to the UDP transmitter.
- `pkt_ack`  in  1  transmitter accepted the request.
- `pkt_done`  in  1  one-cycle pulse: payload fully read from the FIFO.
- `pkt_len`  out  16  payload bytes, constant LINE_BYTES.
- `frame_num`  out  16  current frame number.
- `line_num`  out  16  line number of the current or pending packet.
- `frame_err`  out  1  one-cycle error pulse.

## Operation
- LINE_BYTES = IM_X × (COLOR_MODE==1 ? 1 : 2), a compile-time constant; elaboration error if it is ≥ 2^FIFO_AW.
- States:
  - IDLE: `out_ready`=0. Go to ARM when `enable`=1.
  - ARM: `out_ready`=1. On `frame_start` go to WAIT_DATA with `line_num`←0.
  - WAIT_DATA: on `fifo_level` ≥ LINE_BYTES go to REQ.
  - REQ: `pkt_req`=1, held until `pkt_ack`=1 is sampled, then go to SEND.
  - SEND: on `pkt_done`:
    - if `line_num`==IM_Y-1: `frame_num`++, wrapping at 16 bits; go to ARM if `enable`, else IDLE.
    - otherwise `line_num`++ and go to WAIT_DATA.
  - FLUSH: `fifo_flush`=1, `out_ready`=0, `frame_err`=1 for exactly one cycle, then go to ARM (or IDLE if `!enable`).
- Error conditions:
  - `fifo_overflow` in any state except IDLE/FLUSH → FLUSH; `frame_num` is not incremented.
  - `frame_start` in WAIT_DATA, REQ or SEND (premature VSYNC): in WAIT_DATA → FLUSH. In REQ or SEND, finish the outstanding packet handshake first, then FLUSH.
  - If `overflow` and `frame_start` arrive in the same cycle, overflow wins.
- `enable` deasserted mid-frame: the frame completes, then the FSM goes to IDLE. `out_ready` stays 1 until the frame ends.
- `pkt_done` outside SEND and `pkt_ack` outside REQ are ignored.

## Timing
- Reset values: `out_ready`=0, `fifo_flush`=0, `pkt_req`=0, `pkt_len`=LINE_BYTES, `frame_num`=0, `line_num`=0, `frame_err`=0; state IDLE.
- All outputs are registered (Moore). The level-threshold match drives `pkt_req` high 1 cycle later.
- `pkt_ack` sampled with `pkt_req`=1 drops `pkt_req` on the next edge. `line_num` is stable from `pkt_req` rise until `pkt_done`.
- `fifo_flush` and `frame_err` are coincident, each exactly one cycle long.
- Reset asserted mid-packet: all outputs return to their reset values on the next edge. No `pkt_done` is awaited.

## Configuration
- `VIDEO_SCHED_TIMEOUT_EN` defined: a watchdog counts cycles spent in WAIT_DATA or SEND. It clears on every state change and on `pkt_done`. Reaching TIMEOUT_CYCLES-1 forces FLUSH.
- Undefined: no counter; the FSM may wait indefinitely.

## Structure
- Shared package `cam_pkg`:
  - COLOR_MODE encodings.
  - bytes-per-pixel function.
  - the FSM state enum.
- Optional sub-module `sched_watchdog`: loadable down-counter with an expiry pulse, instantiated only under the macro.

## Test plan
Bench parameters: IM_X=4, IM_Y=2, COLOR_MODE=2, so LINE_BYTES=8.
- **Nominal frame:** `enable`, `frame_start`, `fifo_level`=8 → `pkt_req` with `line_num`=0 and `pkt_len`=8. After ack+done, level 8 again → `line_num`=1. After its done, `frame_num` 0→1 and state is ARM.
- **Threshold edge:** `fifo_level`=7 for 100 cycles → no `pkt_req`. Level 8 → `pkt_req` exactly 1 cycle later.
- **Overflow in SEND:** `fifo_overflow` pulse → next cycle `fifo_flush`=`frame_err`=1, `out_ready`=0. Following cycle: `out_ready`=1 and `frame_num` unchanged.
- **Premature VSYNC:** `frame_start` in WAIT_DATA with `line_num`=1 → FLUSH. The next `frame_start` restarts at `line_num`=0.
- **Enable drop:** `enable`=0 after line 0 → line 1 is still sent, then IDLE with `out_ready`=0.
- **Watchdog:** with `VIDEO_SCHED_TIMEOUT_EN` and TIMEOUT_CYCLES=16, stall in SEND → `frame_err` at cycle 16.
